scbd_feeder_rr: RTL and testbench
=================================

// Module: scbd_feeder_rr
// PURPOSE
//  Parametrised wavefront feeder between per-WF instruction queues and the scoreboard.
//  Keeps a saturating hunger credit count per WF; refilled by issue vacancy, half-instruction requests and queue reset.
//  Each cycle it arbitrates among hungry, non-empty, valid WFs (fixed-priority or round-robin).
//  Presents one registered WF id with a valid/ready handshake to the scoreboard.
// PARAMETERS
//  NUM_WF    40  number of wavefront slots
//  WFID_W     6  WF id width; must satisfy 2**WFID_W >= NUM_WF
//  CREDIT_W   2  credit counter width; MAX_CREDIT = 2**CREDIT_W-1
//  ARB_MODE   1  0 = fixed priority (lowest index wins), 1 = round-robin
// PORTS
//  clk            in   1         clock, all state on rising edge
//  rst_n          in   1         asynchronous reset, active low
//  valid_wf       in   NUM_WF    WF slot allocated
//  ins_half_reqd  in   1         second half of a 64-bit instr requested
//  ins_half_wfid  in   WFID_W    WF of that request
//  issue_vacant   in   NUM_WF    one issue slot freed per set bit
//  q_empty        in   NUM_WF    instruction queue empty
//  q_reset        in   NUM_WF    queue flushed (branch/halt); credit reloads
//  feed_ready     in   1         scoreboard accepts the feed this cycle
//  feed_valid     out  1         registered: feed_wfid holds a selection
//  feed_wfid      out  WFID_W    registered selected WF id
// BEHAVIOUR
//  Reset (rst_n=0, async): credit[i]=MAX_CREDIT for all i; feed_valid=0; feed_wfid=0; rr_ptr=0.
//  Credit update per WF i, one cycle, priority order:
//   1. q_reset[i]: credit = MAX_CREDIT. Pending decrement and increments for i are ignored.
//   2. else: credit = sat(credit + inc - dec), computed in CREDIT_W+2 bits, clamped to [0, MAX_CREDIT].
//      inc = issue_vacant[i] + (ins_half_reqd && ins_half_wfid==i); range 0..2.
//      dec = 1 when i is loaded into the output register this cycle.
//  ins_half_wfid >= NUM_WF is ignored (no credit change).
//  Candidates: cand[i] = (credit[i]!=0) & ~q_empty[i] & valid_wf[i].
//   The WF currently held in the output register (feed_valid && !feed_ready) is excluded from cand.
//  Load condition: load = !feed_valid || feed_ready.
//   On load with any cand: feed_valid<=1, feed_wfid<=winner, credit[winner] decrements.
//   On load with no cand: feed_valid<=0; feed_wfid holds its previous value.
//  Hold: while feed_valid && !feed_ready, feed_wfid is stable and no new selection is made.
//  Drop: while holding, q_reset[feed_wfid] or !valid_wf[feed_wfid] sets feed_valid<=0 next cycle.
//   The consumed credit is not returned; the q_reset reload covers the flush case.
//  Arbitration:
//   ARB_MODE=0: lowest-index candidate wins; this is the legacy feeder ordering.
//   ARB_MODE=1: search starts at rr_ptr and wraps NUM_WF-1 -> 0.
//    rr_ptr <= winner+1 (wrap to 0 past NUM_WF-1) on every load with a winner, otherwise unchanged.
//  Latency: a candidate that becomes eligible in cycle N appears on feed_valid/feed_wfid in N+1.
//  Throughput: with feed_ready held high, one feed per cycle.
//  Simultaneous events on one WF (vacant + half + select) net to +1; saturation applies.
// STRUCTURE
//  Shared constants go in issue_definitions.v: default NUM_WF, WFID_W, and ARB_MODE encodings (ARB_FIXED, ARB_RR).
//  Sub-module rr_arbiter #(N, IDX_W, MODE), purely combinational.
//   Inputs: req[N], ptr. Outputs: grant_onehot[N], grant_idx, any.
//   Implemented as a double-width masked priority search.
//  Top level holds the credit array generate loop, the half-request decoder, the output register and rr_ptr.
// TESTING
//  1. Reset, all WFs valid, q_empty=0, feed_ready=1, MAX_CREDIT=3.
//     -> RR grants 0,1,2,...,39,0,... one per cycle; each WF is granted 3 times total, then feed_valid=0.
//  2. ARB_MODE=0, cand={5,9}, feed_ready=1.
//     -> wfid 5 is fed until its credit reaches 0; only then is 9 fed.
//  3. feed_valid=1, wfid=7, feed_ready=0 for 4 cycles.
//     -> wfid stays 7; credit[7] decrements once; no other grant; on feed_ready=1 the next candidate appears the cycle after.
//  4. Credit[3]=0, issue_vacant[3]=1 and ins_half_reqd with wfid=3 in the same cycle.
//     -> credit[3]=2; WF 3 becomes a candidate one cycle later.
//  5. Holding wfid 12 with feed_ready=0, pulse q_reset[12].
//     -> feed_valid=0 next cycle; credit[12]=3.
//  6. Assert rst_n=0 mid-stream with feed_valid=1.
//     -> feed_valid=0 asynchronously, all credits=3, rr_ptr=0; first grant after release is the lowest candidate.

Source files
------------

// File: rtl/scbd_feeder_rr_pkg.sv
// Shared constants for the scoreboard feeder: default geometry and arbitration modes.
package scbd_feeder_rr_pkg;

  localparam int unsigned NUM_WF_DEF   = 40;
  localparam int unsigned WFID_W_DEF   = 6;
  localparam int unsigned CREDIT_W_DEF = 2;

  // Arbitration mode encodings
  localparam int unsigned ARB_FIXED = 0;
  localparam int unsigned ARB_RR    = 1;

  // Saturation ceiling of a credit counter of the given width
  function automatic int unsigned max_credit(input int unsigned width);
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/scbd_feeder_rr_arbiter.sv
// Combinational arbiter: picks one requester, either lowest index or searching
// upward from i_ptr with wrap, via a double-width masked priority search.
//  i_req            N      request vector
//  i_ptr            IDX_W  round-robin start index (ignored in fixed mode)
//  o_grant_onehot_c N      one-hot grant (all zero when no request)
//  o_grant_idx_c    IDX_W  granted index (zero when no request)
//  o_any_c          1      at least one request present
module scbd_feeder_rr_arbiter
  import scbd_feeder_rr_pkg::*;
#(
  parameter int unsigned N     = NUM_WF_DEF,
  parameter int unsigned IDX_W = WFID_W_DEF,
  parameter int unsigned MODE  = ARB_RR
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N-1:0]     o_grant_onehot_c,
  output logic [IDX_W-1:0] o_grant_idx_c,
  output logic             o_any_c
);

  logic [2*N-1:0] w_dbl;
  int             w_start;
  int             w_hit;
  int             w_idx;

  // Upper copy of the request vector stands in for the wrapped-around part
  // of the search, so masking only the lower copy below the pointer suffices.
  always_comb begin
    w_dbl            = {i_req, i_req};
    w_start          = 0;
    w_hit            = int'(2 * N);
    w_idx            = 0;
    o_grant_onehot_c = '0;
    o_grant_idx_c    = '0;
    o_any_c          = |i_req;

    if (MODE != ARB_FIXED && int'(i_ptr) < int'(N)) begin
      w_start = int'(i_ptr);
    end

    for (int j = int'(2 * N) - 1; j >= 0; j--) begin
      if (w_dbl[j] && j >= w_start) begin
        w_hit = j;
      end
    end

    if (w_hit >= int'(N)) begin
      w_idx = w_hit - int'(N);
    end else begin
      w_idx = w_hit;
    end

    if (o_any_c) begin
      o_grant_idx_c           = IDX_W'(w_idx);
      o_grant_onehot_c[w_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/scbd_feeder_rr.sv
// Wavefront feeder: tracks a saturating hunger credit per WF, arbitrates among
// hungry, non-empty, valid WFs and presents one registered WF id to the scoreboard.
//  clk, rst_n        clock, async active-low reset
//  i_valid_wf        WF slot allocated
//  i_ins_half_reqd   second half of a 64-bit instruction requested
//  i_ins_half_wfid   WF of that request (ids >= NUM_WF ignored)
//  i_issue_vacant    one issue slot freed per set bit (+1 credit)
//  i_q_empty         instruction queue empty
//  i_q_reset         queue flushed; credit reloads to max
//  i_feed_ready      scoreboard accepts the feed this cycle
//  o_feed_valid      registered: o_feed_wfid holds a selection
//  o_feed_wfid       registered selected WF id
module scbd_feeder_rr
  import scbd_feeder_rr_pkg::*;
#(
  parameter int unsigned NUM_WF   = NUM_WF_DEF,
  parameter int unsigned WFID_W   = WFID_W_DEF,
  parameter int unsigned CREDIT_W = CREDIT_W_DEF,
  parameter int unsigned ARB_MODE = ARB_RR
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_WF-1:0] i_valid_wf,
  input  logic              i_ins_half_reqd,
  input  logic [WFID_W-1:0] i_ins_half_wfid,
  input  logic [NUM_WF-1:0] i_issue_vacant,
  input  logic [NUM_WF-1:0] i_q_empty,
  input  logic [NUM_WF-1:0] i_q_reset,
  input  logic              i_feed_ready,
  output logic              o_feed_valid,
  output logic [WFID_W-1:0] o_feed_wfid
);

  localparam int unsigned MAX_CREDIT = max_credit(CREDIT_W);
  localparam int unsigned SUM_W      = CREDIT_W + 2;

  logic              r_feed_valid;
  logic [WFID_W-1:0] r_feed_wfid;
  logic [WFID_W-1:0] r_rr_ptr;

  logic              w_hold;
  logic              w_load;
  logic              w_drop;
  logic [NUM_WF-1:0] w_cand;
  logic [NUM_WF-1:0] w_grant;
  logic [NUM_WF-1:0] w_sel;
  logic [WFID_W-1:0] w_grant_idx;
  logic              w_any;

  logic              w_nxt_valid;
  logic [WFID_W-1:0] w_nxt_wfid;
  logic [WFID_W-1:0] w_nxt_ptr;

  // Output register is stalled while a presented feed is not accepted
  assign w_hold = r_feed_valid & ~i_feed_ready;
  assign w_load = ~w_hold;
  assign w_sel  = w_load ? w_grant : '0;

  // Held WF is abandoned if its queue is flushed or its slot is deallocated
  assign w_drop = i_q_reset[r_feed_wfid] | ~i_valid_wf[r_feed_wfid];

  // Per-WF credit counter, half-request decode and candidate qualification
  for (genvar g = 0; g < NUM_WF; g++) begin : g_credit
    logic [CREDIT_W-1:0] r_credit;
    logic [SUM_W-1:0]    w_sum;
    logic                w_half_hit;

    // Out-of-range request ids never match any slot
    assign w_half_hit = i_ins_half_reqd && (i_ins_half_wfid == WFID_W'(g));

    // Two guard bits: top bit flags underflow, values above max saturate
    assign w_sum = SUM_W'(r_credit) + SUM_W'(i_issue_vacant[g]) + SUM_W'(w_half_hit)
                 - SUM_W'(w_sel[g]);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_credit <= CREDIT_W'(MAX_CREDIT);
      end else if (i_q_reset[g]) begin
        r_credit <= CREDIT_W'(MAX_CREDIT);
      end else if (w_sum[SUM_W-1]) begin
        r_credit <= '0;
      end else if (w_sum > SUM_W'(MAX_CREDIT)) begin
        r_credit <= CREDIT_W'(MAX_CREDIT);
      end else begin
        r_credit <= w_sum[CREDIT_W-1:0];
      end
    end

    assign w_cand[g] = (r_credit != '0) && !i_q_empty[g] && i_valid_wf[g]
                     && !(w_hold && (r_feed_wfid == WFID_W'(g)));
  end

  scbd_feeder_rr_arbiter #(
    .N     (NUM_WF),
    .IDX_W (WFID_W),
    .MODE  (ARB_MODE)
  ) u_arb (
    .i_req            (w_cand),
    .i_ptr            (r_rr_ptr),
    .o_grant_onehot_c (w_grant),
    .o_grant_idx_c    (w_grant_idx),
    .o_any_c          (w_any)
  );

  // Next state of the output register and round-robin pointer
  always_comb begin
    w_nxt_valid = r_feed_valid;
    w_nxt_wfid  = r_feed_wfid;
    w_nxt_ptr   = r_rr_ptr;
    if (w_load) begin
      w_nxt_valid = w_any;
      if (w_any) begin
        w_nxt_wfid = w_grant_idx;
        w_nxt_ptr  = (w_grant_idx == WFID_W'(NUM_WF - 1)) ? '0
                   : w_grant_idx + WFID_W'(1);
      end
    end else if (w_drop) begin
      w_nxt_valid = 1'b0;
    end
  end

  // Output register and round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_feed_valid <= 1'b0;
      r_feed_wfid  <= '0;
      r_rr_ptr     <= '0;
    end else begin
      r_feed_valid <= w_nxt_valid;
      r_feed_wfid  <= w_nxt_wfid;
      r_rr_ptr     <= w_nxt_ptr;
    end
  end

  assign o_feed_valid = r_feed_valid;
  assign o_feed_wfid  = r_feed_wfid;

endmodule

// File: tb/tb_scbd_feeder_rr.sv
// Bench for scbd_feeder_rr: a fixed-priority and a round-robin instance share
// stimulus and are compared against a cycle-level reference model.
module tb_scbd_feeder_rr;

  localparam int NWF  = 40;
  localparam int IW   = 6;
  localparam int MAXC = 3;

  logic           clk;
  logic           rst_n;
  logic [NWF-1:0] valid_wf;
  logic           half_reqd;
  logic [IW-1:0]  half_wfid;
  logic [NWF-1:0] issue_vacant;
  logic [NWF-1:0] q_empty;
  logic [NWF-1:0] q_reset;
  logic           feed_ready;
  logic [1:0]     dut_valid;
  logic [IW-1:0]  dut_wfid [2];

  int total;
  int bad;

  // Reference model state; index 0 = fixed priority, 1 = round robin
  int m_credit [2][NWF];
  bit m_valid  [2];
  int m_wfid   [2];
  int m_ptr    [2];

  scbd_feeder_rr #(.NUM_WF(NWF), .WFID_W(IW), .CREDIT_W(2), .ARB_MODE(0)) u_dut_fix (
    .clk(clk), .rst_n(rst_n), .i_valid_wf(valid_wf), .i_ins_half_reqd(half_reqd),
    .i_ins_half_wfid(half_wfid), .i_issue_vacant(issue_vacant), .i_q_empty(q_empty),
    .i_q_reset(q_reset), .i_feed_ready(feed_ready),
    .o_feed_valid(dut_valid[0]), .o_feed_wfid(dut_wfid[0])
  );

  scbd_feeder_rr #(.NUM_WF(NWF), .WFID_W(IW), .CREDIT_W(2), .ARB_MODE(1)) u_dut_rr (
    .clk(clk), .rst_n(rst_n), .i_valid_wf(valid_wf), .i_ins_half_reqd(half_reqd),
    .i_ins_half_wfid(half_wfid), .i_issue_vacant(issue_vacant), .i_q_empty(q_empty),
    .i_q_reset(q_reset), .i_feed_ready(feed_ready),
    .o_feed_valid(dut_valid[1]), .o_feed_wfid(dut_wfid[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [NWF-1:0] rand_vec(input int pct);
    logic [NWF-1:0] v;
    for (int i = 0; i < NWF; i++) v[i] = ($urandom_range(99) < pct);
    return v;
  endfunction

  task automatic mdl_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < NWF; i++) m_credit[k][i] = MAXC;
      m_valid[k] = 1'b0;
      m_wfid[k]  = 0;
      m_ptr[k]   = 0;
    end
  endtask

  // Advances the model by one clock using the inputs currently applied
  task automatic mdl_step();
    for (int k = 0; k < 2; k++) begin
      bit hold;
      int win;
      int start;
      hold  = m_valid[k] && !feed_ready;
      win   = -1;
      start = (k == 1) ? m_ptr[k] : 0;
      if (!hold) begin
        for (int n = 0; n < NWF; n++) begin
          int idx;
          idx = (start + n) % NWF;
          if (win < 0 && m_credit[k][idx] != 0 && !q_empty[idx] && valid_wf[idx]) win = idx;
        end
      end
      for (int i = 0; i < NWF; i++) begin
        int v;
        if (q_reset[i]) begin
          v = MAXC;
        end else begin
          v = m_credit[k][i] + int'(issue_vacant[i])
            + ((half_reqd && int'(half_wfid) == i) ? 1 : 0) - ((i == win) ? 1 : 0);
          if (v < 0) v = 0;
          if (v > MAXC) v = MAXC;
        end
        m_credit[k][i] = v;
      end
      if (hold) begin
        if (q_reset[m_wfid[k]] || !valid_wf[m_wfid[k]]) m_valid[k] = 1'b0;
      end else if (win >= 0) begin
        m_valid[k] = 1'b1;
        m_wfid[k]  = win;
        m_ptr[k]   = (win + 1) % NWF;
      end else begin
        m_valid[k] = 1'b0;
      end
    end
  endtask

  task automatic step();
    mdl_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle(input logic [NWF-1:0] vwf, input logic rdy);
    valid_wf     = vwf;
    q_empty      = '0;
    q_reset      = '0;
    issue_vacant = '0;
    half_reqd    = 1'b0;
    half_wfid    = '0;
    feed_ready   = rdy;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    mdl_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    set_idle('1, 1'b1);
    rst_n = 1'b0;
    mdl_reset();
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      total++;
      if (dut_valid[k] !== 1'b0 || dut_wfid[k] !== '0) begin
        bad++;
        $display("FAIL reset inst=%0d valid=%0b wfid=%0d expected valid=0 wfid=0",
                 k, dut_valid[k], dut_wfid[k]);
      end
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // All WFs hungry: RR sweeps 0..39 three times, fixed serves each WF thrice in a row
  task automatic test_rr_drain();
    do_reset();
    set_idle('1, 1'b1);
    for (int c = 0; c < 3 * NWF; c++) begin
      step();
      total++;
      if (dut_valid[1] !== 1'b1 || dut_wfid[1] !== IW'(c % NWF)) begin
        bad++;
        $display("FAIL rr_drain cyc=%0d valid=%0b wfid=%0d expected valid=1 wfid=%0d",
                 c, dut_valid[1], dut_wfid[1], c % NWF);
      end
      total++;
      if (dut_valid[0] !== 1'b1 || dut_wfid[0] !== IW'(c / 3)) begin
        bad++;
        $display("FAIL fix_drain cyc=%0d valid=%0b wfid=%0d expected valid=1 wfid=%0d",
                 c, dut_valid[0], dut_wfid[0], c / 3);
      end
    end
    step();
    for (int k = 0; k < 2; k++) begin
      total++;
      if (dut_valid[k] !== 1'b0) begin
        bad++;
        $display("FAIL drain_empty inst=%0d valid=%0b expected valid=0", k, dut_valid[k]);
      end
    end
  endtask

  // Fixed priority keeps feeding WF 5 until its credit runs out, then WF 9
  task automatic test_fixed_priority();
    logic [NWF-1:0] v;
    int exp_fix [6];
    exp_fix = '{5, 5, 5, 9, 9, 9};
    do_reset();
    v = '0;
    v[5] = 1'b1;
    v[9] = 1'b1;
    set_idle(v, 1'b1);
    for (int c = 0; c < 7; c++) begin
      step();
      for (int k = 0; k < 2; k++) begin
        total++;
        if (dut_valid[k] !== m_valid[k] || dut_wfid[k] !== IW'(m_wfid[k])) begin
          bad++;
          $display("FAIL prio_model inst=%0d cyc=%0d valid=%0b wfid=%0d expected valid=%0b wfid=%0d",
                   k, c, dut_valid[k], dut_wfid[k], m_valid[k], m_wfid[k]);
        end
      end
      total++;
      if (c < 6 && (dut_valid[0] !== 1'b1 || dut_wfid[0] !== IW'(exp_fix[c]))) begin
        bad++;
        $display("FAIL prio_order cyc=%0d valid=%0b wfid=%0d expected valid=1 wfid=%0d",
                 c, dut_valid[0], dut_wfid[0], exp_fix[c]);
      end else if (c == 6 && dut_valid[0] !== 1'b0) begin
        bad++;
        $display("FAIL prio_order cyc=%0d valid=%0b expected valid=0", c, dut_valid[0]);
      end
    end
  endtask

  // Stalled feed holds WF 7 and consumes one credit only
  task automatic test_hold();
    logic [NWF-1:0] v;
    int exp_fix [3];
    exp_fix = '{7, 7, 8};
    do_reset();
    v = '0;
    v[7] = 1'b1;
    v[8] = 1'b1;
    set_idle(v, 1'b0);
    for (int c = 0; c < 5; c++) begin
      step();
      for (int k = 0; k < 2; k++) begin
        total++;
        if (dut_valid[k] !== 1'b1 || dut_wfid[k] !== IW'(7)) begin
          bad++;
          $display("FAIL hold inst=%0d cyc=%0d valid=%0b wfid=%0d expected valid=1 wfid=7",
                   k, c, dut_valid[k], dut_wfid[k]);
        end
      end
    end
    feed_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      total++;
      if (dut_valid[0] !== 1'b1 || dut_wfid[0] !== IW'(exp_fix[c])) begin
        bad++;
        $display("FAIL hold_release_fix cyc=%0d valid=%0b wfid=%0d expected valid=1 wfid=%0d",
                 c, dut_valid[0], dut_wfid[0], exp_fix[c]);
      end
      total++;
      if (dut_valid[1] !== m_valid[1] || dut_wfid[1] !== IW'(m_wfid[1])) begin
        bad++;
        $display("FAIL hold_release_rr cyc=%0d valid=%0b wfid=%0d expected valid=%0b wfid=%0d",
                 c, dut_valid[1], dut_wfid[1], m_valid[1], m_wfid[1]);
      end
    end
    total++;
    if (dut_wfid[1] !== IW'(8) && dut_wfid[1] !== IW'(7)) begin
      bad++;
      $display("FAIL hold_release_rr_id wfid=%0d expected 7 or 8", dut_wfid[1]);
    end
  endtask

  // Vacancy plus half request on an exhausted WF nets +2 credit
  task automatic test_refill();
    logic [NWF-1:0] v;
    int exp_v [6];
    exp_v = '{1, 1, 1, 0, 0, 1};
    do_reset();
    v = '0;
    v[3] = 1'b1;
    set_idle(v, 1'b1);
    for (int c = 0; c < 9; c++) begin
      if (c == 4) begin
        issue_vacant[3] = 1'b1;
        half_reqd       = 1'b1;
        half_wfid       = IW'(3);
      end else begin
        issue_vacant = '0;
        half_reqd    = 1'b0;
        half_wfid    = IW'(45);
      end
      step();
      for (int k = 0; k < 2; k++) begin
        total++;
        if (c < 6 && dut_valid[k] !== 1'(exp_v[c])) begin
          bad++;
          $display("FAIL refill inst=%0d cyc=%0d valid=%0b expected valid=%0d",
                   k, c, dut_valid[k], exp_v[c]);
        end else if (c >= 6 && dut_valid[k] !== ((c == 6) ? 1'b1 : 1'b0)) begin
          bad++;
          $display("FAIL refill inst=%0d cyc=%0d valid=%0b expected valid=%0b",
                   k, c, dut_valid[k], (c == 6));
        end
      end
    end
  endtask

  // Flushing the held WF drops the feed and reloads its credit to max
  task automatic test_qreset_drop();
    logic [NWF-1:0] v;
    int exp_fix [4];
    exp_fix = '{12, 12, 12, 13};
    do_reset();
    v = '0;
    v[12] = 1'b1;
    v[13] = 1'b1;
    set_idle(v, 1'b0);
    step();
    q_reset[12] = 1'b1;
    step();
    q_reset = '0;
    for (int k = 0; k < 2; k++) begin
      total++;
      if (dut_valid[k] !== 1'b0 || dut_wfid[k] !== IW'(12)) begin
        bad++;
        $display("FAIL qreset_drop inst=%0d valid=%0b wfid=%0d expected valid=0 wfid=12",
                 k, dut_valid[k], dut_wfid[k]);
      end
    end
    for (int c = 0; c < 4; c++) begin
      step();
      feed_ready = 1'b1;
      total++;
      if (dut_valid[0] !== 1'b1 || dut_wfid[0] !== IW'(exp_fix[c])) begin
        bad++;
        $display("FAIL qreset_credit cyc=%0d valid=%0b wfid=%0d expected valid=1 wfid=%0d",
                 c, dut_valid[0], dut_wfid[0], exp_fix[c]);
      end
      total++;
      if (dut_valid[1] !== m_valid[1] || dut_wfid[1] !== IW'(m_wfid[1])) begin
        bad++;
        $display("FAIL qreset_rr cyc=%0d valid=%0b wfid=%0d expected valid=%0b wfid=%0d",
                 c, dut_valid[1], dut_wfid[1], m_valid[1], m_wfid[1]);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    set_idle('1, 1'b1);
    for (int c = 0; c < 1500; c++) begin
      valid_wf     = rand_vec(90);
      q_empty      = rand_vec(20);
      issue_vacant = rand_vec(15);
      q_reset      = rand_vec(2);
      half_reqd    = 1'($urandom_range(1));
      half_wfid    = IW'($urandom_range(63));
      feed_ready   = ($urandom_range(99) < 70);
      step();
      for (int k = 0; k < 2; k++) begin
        total++;
        if (dut_valid[k] !== m_valid[k] || dut_wfid[k] !== IW'(m_wfid[k])) begin
          bad++;
          $display("FAIL random inst=%0d cyc=%0d valid=%0b wfid=%0d expected valid=%0b wfid=%0d",
                   k, c, dut_valid[k], dut_wfid[k], m_valid[k], m_wfid[k]);
        end
      end
    end
  endtask

  // Reset mid-stream clears outputs at once; afterwards the lowest candidate wins
  task automatic test_async_reset();
    logic [NWF-1:0] v;
    int low;
    do_reset();
    set_idle('1, 1'b1);
    for (int c = 0; c < 10; c++) begin
      step();
      for (int k = 0; k < 2; k++) begin
        total++;
        if (dut_valid[k] !== m_valid[k] || dut_wfid[k] !== IW'(m_wfid[k])) begin
          bad++;
          $display("FAIL pre_reset inst=%0d cyc=%0d valid=%0b wfid=%0d expected valid=%0b wfid=%0d",
                   k, c, dut_valid[k], dut_wfid[k], m_valid[k], m_wfid[k]);
        end
      end
    end
    #2;
    rst_n = 1'b0;
    mdl_reset();
    #1;
    for (int k = 0; k < 2; k++) begin
      total++;
      if (dut_valid[k] !== 1'b0 || dut_wfid[k] !== '0) begin
        bad++;
        $display("FAIL async_reset inst=%0d valid=%0b wfid=%0d expected valid=0 wfid=0",
                 k, dut_valid[k], dut_wfid[k]);
      end
    end
    v = rand_vec(30);
    v[$urandom_range(NWF - 1)] = 1'b1;
    low = -1;
    for (int i = NWF - 1; i >= 0; i--) if (v[i]) low = i;
    set_idle(v, 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    for (int k = 0; k < 2; k++) begin
      total++;
      if (dut_valid[k] !== 1'b1 || dut_wfid[k] !== IW'(low)) begin
        bad++;
        $display("FAIL post_reset_grant inst=%0d valid=%0b wfid=%0d expected valid=1 wfid=%0d",
                 k, dut_valid[k], dut_wfid[k], low);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    set_idle('1, 1'b1);
    mdl_reset();
    test_reset();
    test_rr_drain();
    test_fixed_priority();
    test_hold();
    test_refill();
    test_qreset_drop();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
